// File: rtl/instr_fetch_unit.sv
//-----------------------------------------------------------------------------
// instr_fetch_unit
//
// Upstream stage of the MBRU. Holds the program counter and reads 16-bit
// instruction words from instruction memory over a req/valid handshake. It
// presents each word on instr_word with a one-cycle fetch pulse. It advances
// only when the control unit asks for the next word (next) or redirects the
// PC (jump_en). A watchdog moves the unit to ERR when memory never answers.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin/resume fetching from pc (looked at in IDLE and ERR)
//   next        in   request next instruction (looked at in HOLD)
//   jump_en     in   load jump_addr into pc and fetch from it (HOLD)
//   jump_addr   in   jump target, ADDR_W bits
//   halt        in   abandon fetching and return to IDLE (WAIT/ISSUE/HOLD)
//   imem_req    out  memory read request, level, held until imem_valid
//   imem_addr   out  memory read address (pc while imem_req=1, else 0)
//   imem_data   in   memory read data, 16 bits
//   imem_valid  in   read data valid, one-cycle pulse
//   fetch       out  one-cycle pulse: instr_word carries a new word
//   instr_word  out  registered instruction word, 16 bits
//   pc          out  current program counter
//   busy        out  high in WAIT, ISSUE, HOLD
//   err         out  high in ERR
//
// All outputs come from registers or from the state register alone, so
// there is no combinational path from any input to any output.
//-----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              next,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              imem_valid,
    output logic              fetch,
    output logic [15:0]       instr_word,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              err
);

    // The timer only needs to reach TIMEOUT-1.
    localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    //-------------------------------------------------------------------------
    // State and datapath registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            timer_q <= timer_d;
        end
    end

    //-------------------------------------------------------------------------
    // Next-state logic
    //-------------------------------------------------------------------------
    // The timer defaults to zero. It counts only while WAIT is held without
    // data, so every entry into WAIT (from IDLE, HOLD or ERR) starts a fresh
    // watchdog window.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        timer_d = '0;

        case (state_q)
            S_IDLE: begin
                // A stray imem_valid here belongs to an abandoned request.
                if (start) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (halt) begin
                    // Drop the outstanding request. pc is unchanged.
                    state_d = S_IDLE;
                end else if (imem_valid) begin
                    // Data beats the watchdog even on its final cycle.
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ISSUE: begin
                // The increment commits even when halt arrives here.
                pc_d    = pc_q + 1'b1;
                state_d = halt ? S_IDLE : S_HOLD;
            end

            S_HOLD: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = S_WAIT;
                end else if (next) begin
                    state_d = S_WAIT;
                end
            end

            S_ERR: begin
                // Retry the same pc. halt cannot leave ERR.
                if (start) begin
                    state_d = S_WAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Outputs: decoded from the state register or taken straight from
    // registers
    //-------------------------------------------------------------------------
    assign imem_req   = (state_q == S_WAIT);
    assign imem_addr  = (state_q == S_WAIT) ? pc_q : '0;
    assign fetch      = (state_q == S_ISSUE);
    assign busy       = (state_q == S_WAIT) || (state_q == S_ISSUE) ||
                        (state_q == S_HOLD);
    assign err        = (state_q == S_ERR);
    assign instr_word = instr_q;
    assign pc         = pc_q;

endmodule
